// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator. A horizontal/vertical counter pair walks
// the full frame (active, front porch, sync, back porch). Every pixel tick the
// current position is registered into the request stage. The request stage
// drives the frame buffer or pattern source. A PREFETCH-deep shift pipeline
// then delays position, active flag and raw sync bits, so the colour returned
// by a source with PREFETCH-1 ticks of latency lines up with the sync and
// active window seen at the connector.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   pix_en          pixel tick; all state advances only on edges with pix_en=1
//   data            pixel colour from the source
//   oReq            request stage: position is visible
//   oReqX, oReqY    request stage: horizontal / vertical position
//   oFrameStart     request stage: position (0,0)
//   oLineStart      request stage: start of a line
//   oCtrH, oCtrV    display stage: horizontal / vertical position
//   oActive         display stage: visible pixel
//   colorChannels   displayed colour, forced to 0 when blanked
//   oHSync, oVSync  sync outputs with configurable active level
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int COLOR_W   = 3,
    parameter int PREFETCH  = 1,
    parameter int CTR_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [COLOR_W-1:0] data,
    output logic               oReq,
    output logic [CTR_W-1:0]   oReqX,
    output logic [CTR_W-1:0]   oReqY,
    output logic               oFrameStart,
    output logic               oLineStart,
    output logic [CTR_W-1:0]   oCtrH,
    output logic [CTR_W-1:0]   oCtrV,
    output logic               oActive,
    output logic [COLOR_W-1:0] colorChannels,
    output logic               oHSync,
    output logic               oVSync
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CTR_W-1:0] H_LAST = CTR_W'(H_TOTAL - 1);
    localparam logic [CTR_W-1:0] V_LAST = CTR_W'(V_TOTAL - 1);
    localparam logic             HS_ON  = (HSYNC_POL != 0);
    localparam logic             VS_ON  = (VSYNC_POL != 0);

    logic [CTR_W-1:0] hc_q, hc_d;
    logic [CTR_W-1:0] vc_q, vc_d;

    // Pipeline index 0 is the request stage, index PREFETCH the display stage.
    logic [PREFETCH:0]  act_q;
    logic [PREFETCH:0]  hs_q;
    logic [PREFETCH:0]  vs_q;
    logic [CTR_W-1:0]   x_q [PREFETCH+1];
    logic [CTR_W-1:0]   y_q [PREFETCH+1];
    logic               fs_q, ls_q;
    logic [COLOR_W-1:0] color_q;

    logic req_d, hs_raw_d, vs_raw_d, ls_d, fs_d;

    always_comb begin
        hc_d = hc_q + CTR_W'(1);
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + CTR_W'(1);
        end
        // Sync windows are compared in int so an end bound equal to the
        // total count cannot overflow the counter width.
        req_d    = (int'(hc_q) < H_ACTIVE) && (int'(vc_q) < V_ACTIVE);
        hs_raw_d = (int'(hc_q) >= HS_START) && (int'(hc_q) < HS_END);
        vs_raw_d = (int'(vc_q) >= VS_START) && (int'(vc_q) < VS_END);
        ls_d     = (hc_q == '0);
        fs_d     = ls_d && (vc_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q    <= '0;
            vc_q    <= '0;
            act_q   <= '0;
            hs_q    <= '0;
            vs_q    <= '0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            color_q <= '0;
            for (int i = 0; i <= PREFETCH; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else if (pix_en) begin
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            fs_q  <= fs_d;
            ls_q  <= ls_d;
            act_q <= {act_q[PREFETCH-1:0], req_d};
            hs_q  <= {hs_q[PREFETCH-1:0], hs_raw_d};
            vs_q  <= {vs_q[PREFETCH-1:0], vs_raw_d};
            x_q[0] <= hc_q;
            y_q[0] <= vc_q;
            for (int i = 1; i <= PREFETCH; i++) begin
                x_q[i] <= x_q[i-1];
                y_q[i] <= y_q[i-1];
            end
            // Colour is captured on the same edge that makes the pixel
            // visible, gated by the active bit entering the display stage.
            color_q <= act_q[PREFETCH-1] ? data : '0;
        end
    end

    assign oReq          = act_q[0];
    assign oReqX         = x_q[0];
    assign oReqY         = y_q[0];
    assign oFrameStart   = fs_q;
    assign oLineStart    = ls_q;
    assign oActive       = act_q[PREFETCH];
    assign oCtrH         = x_q[PREFETCH];
    assign oCtrV         = y_q[PREFETCH];
    assign colorChannels = color_q;
    assign oHSync        = hs_q[PREFETCH] ? HS_ON : ~HS_ON;
    assign oVSync        = vs_q[PREFETCH] ? VS_ON : ~VS_ON;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one clock:
//   A: default horizontal timing, shortened vertical (4/1/2/1), PREFETCH=1
//   B: small frame H 4/1/2/1, V 3/1/1/1, PREFETCH=2, 1-tick-latency source
//   C: same small frame, PREFETCH=1, active-high syncs
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A ----------------
    logic        a_rst, a_en;
    logic [2:0]  a_data;
    logic        a_req, a_fs, a_ls, a_act, a_hs, a_vs;
    logic [10:0] a_rx, a_ry, a_ch, a_cv;
    logic [2:0]  a_col;

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PREFETCH(1)
    ) u_a (
        .clk(clk), .rst(a_rst), .pix_en(a_en), .data(a_data),
        .oReq(a_req), .oReqX(a_rx), .oReqY(a_ry), .oFrameStart(a_fs),
        .oLineStart(a_ls), .oCtrH(a_ch), .oCtrV(a_cv), .oActive(a_act),
        .colorChannels(a_col), .oHSync(a_hs), .oVSync(a_vs)
    );

    // ---------------- instance B ----------------
    logic        b_rst, b_en;
    logic [2:0]  b_data;
    logic        b_req, b_fs, b_ls, b_act, b_hs, b_vs;
    logic [10:0] b_rx, b_ry, b_ch, b_cv;
    logic [2:0]  b_col;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PREFETCH(2)
    ) u_b (
        .clk(clk), .rst(b_rst), .pix_en(b_en), .data(b_data),
        .oReq(b_req), .oReqX(b_rx), .oReqY(b_ry), .oFrameStart(b_fs),
        .oLineStart(b_ls), .oCtrH(b_ch), .oCtrV(b_cv), .oActive(b_act),
        .colorChannels(b_col), .oHSync(b_hs), .oVSync(b_vs)
    );

    // Pattern source with one tick of read latency.
    always @(posedge clk) begin
        if (b_rst)     b_data <= 3'b000;
        else if (b_en) b_data <= {b_rx[1:0], b_ry[0]};
    end

    // ---------------- instance C ----------------
    logic        c_rst, c_en;
    logic [2:0]  c_data;
    logic        c_req, c_fs, c_ls, c_act, c_hs, c_vs;
    logic [10:0] c_rx, c_ry, c_ch, c_cv;
    logic [2:0]  c_col;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .PREFETCH(1)
    ) u_c (
        .clk(clk), .rst(c_rst), .pix_en(c_en), .data(c_data),
        .oReq(c_req), .oReqX(c_rx), .oReqY(c_ry), .oFrameStart(c_fs),
        .oLineStart(c_ls), .oCtrH(c_ch), .oCtrV(c_cv), .oActive(c_act),
        .colorChannels(c_col), .oHSync(c_hs), .oVSync(c_vs)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [52:0] snap_b();
        return {b_req, b_rx, b_ry, b_fs, b_ls, b_ch, b_cv, b_act, b_col, b_hs, b_vs};
    endfunction

    typedef struct {
        int rst; int en;
        int req; int fs; int ls; int x; int y;
        int act; int ch; int cv; int col; int hs; int vs;
    } vec_t;

    vec_t tbl [18];

    // Wait for request position (x,y) on A, pulse reset, check the flush and
    // the clean restart.
    task automatic reset_a_at(input int x, input int y, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20000 && !found; k++) begin
            step();
            if (a_rx == 11'(x) && a_ry == 11'(y)) found = 1'b1;
        end
        check({tag, ".reached"}, 32'(found), 1);
        a_rst = 1'b1;
        step();
        check({tag, ".rst_act"},   32'(a_act), 0);
        check({tag, ".rst_col"},   32'(a_col), 0);
        check({tag, ".rst_hs"},    32'(a_hs),  1);
        check({tag, ".rst_vs"},    32'(a_vs),  1);
        check({tag, ".rst_req"},   32'(a_req), 0);
        check({tag, ".rst_fs"},    32'(a_fs),  0);
        check({tag, ".rst_ctrh"},  32'(a_ch),  0);
        a_rst = 1'b0;
        step();
        check({tag, ".rel_rx"},    32'(a_rx),  0);
        check({tag, ".rel_ry"},    32'(a_ry),  0);
        check({tag, ".rel_fs"},    32'(a_fs),  1);
        check({tag, ".rel_act"},   32'(a_act), 0);
        step();
        check({tag, ".act_rise"},  32'(a_act), 1);
        check({tag, ".act_ctrh"},  32'(a_ch),  0);
        check({tag, ".act_col"},   32'(a_col), 5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n_act, bad, hold_bad;
        int fs_t[$];
        int ls_t[$];
        logic [52:0] prev;
        logic prev_fs, prev_ls;
        int hs_start, hs_end, hs_len, vs_first, vs_last, vs_len;
        bit hs_in, hs_done, vs_in, vs_done, prev_hs, prev_vs;
        int a_fs_cnt, a_col_bad, c_hs_bad, c_vs_bad, c_col_bad, c_hs_hi, c_vs_hi;

        a_rst = 1'b1; a_en = 1'b0; a_data = 3'b101;
        b_rst = 1'b1; b_en = 1'b0;
        c_rst = 1'b1; c_en = 1'b0; c_data = 3'b111;

        //            rst en req fs ls x  y act ch cv col hs vs
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[4]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{0, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 1, 1, 0, 0, 3, 0, 1, 1, 0, 2, 1, 1};
        tbl[8]  = '{0, 1, 0, 0, 0, 4, 0, 1, 2, 0, 4, 1, 1};
        tbl[9]  = '{0, 1, 0, 0, 0, 5, 0, 1, 3, 0, 6, 1, 1};
        tbl[10] = '{0, 1, 0, 0, 0, 6, 0, 0, 4, 0, 0, 1, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 7, 0, 0, 5, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 1, 0, 1, 0, 1, 0, 6, 0, 0, 0, 1};
        tbl[13] = '{0, 1, 1, 0, 0, 1, 1, 0, 7, 0, 0, 1, 1};
        tbl[14] = '{0, 1, 1, 0, 0, 2, 1, 1, 0, 1, 1, 1, 1};
        tbl[15] = '{0, 1, 1, 0, 0, 3, 1, 1, 1, 1, 3, 1, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[17] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};

        // ---- B: directed vector table ----
        for (int i = 0; i < 18; i++) begin
            b_rst = (tbl[i].rst != 0);
            b_en  = (tbl[i].en != 0);
            step();
            check($sformatf("v%0d.req", i),  32'(b_req), tbl[i].req);
            check($sformatf("v%0d.fs", i),   32'(b_fs),  tbl[i].fs);
            check($sformatf("v%0d.ls", i),   32'(b_ls),  tbl[i].ls);
            check($sformatf("v%0d.rx", i),   32'(b_rx),  tbl[i].x);
            check($sformatf("v%0d.ry", i),   32'(b_ry),  tbl[i].y);
            check($sformatf("v%0d.act", i),  32'(b_act), tbl[i].act);
            check($sformatf("v%0d.ctrh", i), 32'(b_ch),  tbl[i].ch);
            check($sformatf("v%0d.ctrv", i), 32'(b_cv),  tbl[i].cv);
            check($sformatf("v%0d.col", i),  32'(b_col), tbl[i].col);
            check($sformatf("v%0d.hs", i),   32'(b_hs),  tbl[i].hs);
            check($sformatf("v%0d.vs", i),   32'(b_vs),  tbl[i].vs);
        end

        // ---- B: steady-state frame, colour alignment ----
        b_rst = 1'b1; b_en = 1'b1;
        step();
        b_rst = 1'b0;
        for (int i = 0; i < 100; i++) step();
        n_act = 0; bad = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (b_act) begin
                n_act++;
                if (b_col != {b_ch[1:0], b_cv[0]}) bad++;
            end else if (b_col != 3'b000) begin
                bad++;
            end
        end
        check("B.active_per_frame", 32'(n_act), 12);
        check("B.pixel_colour_errs", 32'(bad), 0);

        // ---- B: pix_en every 4th clock ----
        b_rst = 1'b1; b_en = 1'b0;
        step();
        b_rst = 1'b0;
        prev = snap_b(); prev_fs = b_fs; prev_ls = b_ls; hold_bad = 0;
        for (int cyc = 0; cyc < 4 * 48 * 2 + 40; cyc++) begin
            b_en = (cyc % 4 == 0);
            step();
            if (!b_en && snap_b() != prev) hold_bad++;
            if (b_fs && !prev_fs) fs_t.push_back(cyc);
            if (b_ls && !prev_ls) ls_t.push_back(cyc);
            prev = snap_b(); prev_fs = b_fs; prev_ls = b_ls;
        end
        check("B.hold_when_idle_errs", 32'(hold_bad), 0);
        check("B.frame_starts", 32'(fs_t.size()), 3);
        check("B.frame_period_x4", (fs_t.size() >= 2) ? 32'(fs_t[1] - fs_t[0]) : 32'(0), 192);
        check("B.line_period_x4",  (ls_t.size() >= 2) ? 32'(ls_t[1] - ls_t[0]) : 32'(0), 32);
        b_en = 1'b1;

        // ---- A: default horizontal timing ----
        a_rst = 1'b1; a_en = 1'b1;
        step();
        check("A.reset_hs", 32'(a_hs), 1);
        check("A.reset_vs", 32'(a_vs), 1);
        check("A.reset_ls", 32'(a_ls), 0);
        a_rst = 1'b0;
        fs_t.delete(); ls_t.delete();
        hs_start = -1; hs_end = -1; hs_len = 0; hs_in = 0; hs_done = 0; prev_hs = 1;
        vs_first = -1; vs_last = -1; vs_len = 0; vs_in = 0; vs_done = 0; prev_vs = 1;
        a_fs_cnt = 0; a_col_bad = 0;
        for (int cyc = 1; cyc <= 12850; cyc++) begin
            step();
            if (a_fs) begin a_fs_cnt++; fs_t.push_back(cyc); end
            if (a_ls) ls_t.push_back(cyc);
            if (a_col != (a_act ? 3'b101 : 3'b000)) a_col_bad++;
            if (!hs_done) begin
                if (!a_hs && prev_hs) begin hs_in = 1; hs_start = int'(a_ch); hs_len = 0; end
                if (!a_hs && hs_in) begin hs_len++; hs_end = int'(a_ch); end
                if (a_hs && hs_in) begin hs_in = 0; hs_done = 1; end
            end
            if (!vs_done) begin
                if (!a_vs && prev_vs) begin vs_in = 1; vs_first = int'(a_cv); vs_len = 0; end
                if (!a_vs && vs_in) begin vs_len++; vs_last = int'(a_cv); end
                if (a_vs && vs_in) begin vs_in = 0; vs_done = 1; end
            end
            prev_hs = a_hs; prev_vs = a_vs;
        end
        check("A.hsync_width",  32'(hs_len),   96);
        check("A.hsync_start",  32'(hs_start), 656);
        check("A.hsync_end",    32'(hs_end),   751);
        check("A.line_period",  (ls_t.size() >= 2) ? 32'(ls_t[1] - ls_t[0]) : 32'(0), 800);
        check("A.vsync_first",  32'(vs_first), 5);
        check("A.vsync_last",   32'(vs_last),  6);
        check("A.vsync_ticks",  32'(vs_len),   1600);
        check("A.frame_starts", 32'(a_fs_cnt), 3);
        check("A.frame_period", (fs_t.size() >= 2) ? 32'(fs_t[1] - fs_t[0]) : 32'(0), 6400);
        check("A.colour_errs",  32'(a_col_bad), 0);

        // ---- A: mid-frame resets (in active video, then inside both syncs) ----
        reset_a_at(300, 2, "A.rst_active");
        reset_a_at(700, 5, "A.rst_sync");

        // ---- C: active-high syncs ----
        c_rst = 1'b1; c_en = 1'b1;
        step();
        step();
        check("C.reset_hs_idle", 32'(c_hs), 0);
        check("C.reset_vs_idle", 32'(c_vs), 0);
        c_rst = 1'b0;
        c_hs_bad = 0; c_vs_bad = 0; c_col_bad = 0; c_hs_hi = 0; c_vs_hi = 0;
        for (int cyc = 1; cyc <= 96; cyc++) begin
            step();
            if (cyc == 1) begin
                check("C.first_req",  32'(c_req), 1);
                check("C.first_fs",   32'(c_fs),  1);
                check("C.first_ls",   32'(c_ls),  1);
                check("C.first_rxry", 32'({c_rx, c_ry}), 0);
            end
            if (c_hs) c_hs_hi++;
            if (c_vs) c_vs_hi++;
            if (c_hs != (c_ch >= 11'd5 && c_ch <= 11'd6)) c_hs_bad++;
            if (c_vs != (c_cv == 11'd4)) c_vs_bad++;
            if (c_col != (c_act ? 3'b111 : 3'b000)) c_col_bad++;
        end
        check("C.hs_position_errs", 32'(c_hs_bad), 0);
        check("C.vs_position_errs", 32'(c_vs_bad), 0);
        check("C.hs_high_ticks",    32'(c_hs_hi), 24);
        check("C.vs_high_ticks",    32'(c_vs_hi), 16);
        check("C.colour_errs",      32'(c_col_bad), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. Successor to the fixed-timing 3-bit VGA controller.
- Produces HSync, VSync, blanking and pixel colour for any resolution and porch set.
- Runs from the system clock, gated by a pixel-clock enable.
- Issues pixel requests (X/Y) to a frame buffer or pattern source of known read latency ahead of display, so returned colour aligns with its sync/active window.
- Sits between the frame-buffer/pattern logic and the VGA connector pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync pulse width (ticks, >=1)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines, >=1)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of oHSync (0 = active-low)
VSYNC_POL, 0, active level of oVSync
COLOR_W, 3, colour bus width
PREFETCH, 1, request-to-display lead in ticks, 1..4; source latency = PREFETCH-1 ticks
CTR_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel tick; all timing advances only on clk edges with pix_en=1
data  in  COLOR_W  pixel colour from source
oReq  out  1  request stage: current position is visible
oReqX  out  CTR_W  request-stage horizontal count
oReqY  out  CTR_W  request-stage vertical count
oFrameStart  out  1  request stage: position (0,0)
oLineStart  out  1  request stage: hc==0
oCtrH  out  CTR_W  display-stage horizontal count
oCtrV  out  CTR_W  display-stage vertical count
oActive  out  1  display stage: visible pixel
colorChannels  out  COLOR_W  pixel colour, 0 when blanked
oHSync  out  1  horizontal sync, polarity HSYNC_POL
oVSync  out  1  vertical sync, polarity VSYNC_POL

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active [0,H_ACTIVE), front porch, sync, back porch. Same order vertically, in lines.
- Counters hc, vc. On each tick, hc increments.
  - hc==H_TOTAL-1: hc→0 and vc increments.
  - vc==V_TOTAL-1 at that wrap: vc→0.
  - No other wrap is possible.
- Request stage (registered, updated every tick):
  - oReqX=hc, oReqY=vc.
  - oReq=(hc<H_ACTIVE && vc<V_ACTIVE).
  - oLineStart=(hc==0); oFrameStart=(hc==0 && vc==0).
  - All are levels held for the whole tick period (one or more clk cycles).
- Display stage: a PREFETCH-deep shift pipeline, advanced only on ticks, delays the following request-stage values by exactly PREFETCH ticks:
  - oReq→oActive
  - oReqX/oReqY→oCtrH/oCtrV
  - hsync_raw=(H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC)→oHSync
  - vsync_raw (same rule in lines, on vc)→oVSync
- Sync output level = raw ? POL : ~POL.
- colorChannels loads on the tick edge that loads the display stage: data if the incoming active bit is 1, else 0.
  - The source must present the pixel for (oReqX,oReqY) PREFETCH-1 ticks after oReq asserts and hold it through that edge.
- pix_en=0: every register holds; no output changes.
- Reset (rst=1 at a clk edge, regardless of pix_en):
  - hc=vc=0.
  - Request outputs 0, except oLineStart=oFrameStart=0 until the first tick.
  - Pipeline flushed: oActive=0, colorChannels=0, oCtrH=oCtrV=0, oHSync=~HSYNC_POL, oVSync=~VSYNC_POL.
  - First tick after reset release loads the request stage with (0,0): oReq=1, oFrameStart=1.
  - oActive first rises PREFETCH ticks later.
- Reset mid-frame: same as above; no partial sync pulse is extended; the next frame starts cleanly.
- Porch parameters of 0 are legal.

Test Plan:
- Default params, pix_en=1, PREFETCH=1, data=3'b101:
  - oHSync low exactly 96 ticks, from display hc=656 to 751.
  - Line period 800 ticks; oVSync low for lines 490-491.
  - Frame period 420000 ticks; oFrameStart once per frame.
  - colorChannels=101 only while oActive.
- Small frame (H 4/1/2/1, V 3/1/1/1, PREFETCH=2), bench source returns {oReqX[1:0],oReqY[0]} with 1-tick latency:
  - Every displayed colorChannels equals the expected value for (oCtrH,oCtrV).
  - 12 active pixels per 48-tick frame.
- pix_en high every 4th clk:
  - All periods scale ×4.
  - Outputs change only on clk edges with pix_en=1.
- Assert rst for 1 clk at hc=300, vc=200, then resume:
  - Next edge shows oActive=0, syncs inactive, colorChannels=0.
  - First tick after release gives oReqX=0, oReqY=0, oFrameStart=1.
- HSYNC_POL=1, VSYNC_POL=1: sync pulses are high with identical timing; idle level is low, including during reset.
